circuit_4_5_sweep: RTL and testbench
====================================

# circuit_4_5_sweep

Sequencer that drives the 3-input/3-output combinational function block (A = x'y + yz, B = xyz' + x'y' + y'z, C = x ^ z) through its input space. It applies codes, waits a settle interval, samples {A,B,C}, streams each result out and optionally checks it against a built-in golden model. It sits between a test/host controller and one instance of the function block, replacing the free-running testbench stimulus with a clocked, handshaked sweep.

## Interface
- SETTLE, default 1, cycles an applied code is held before sampling; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- sweep  input  1  1 = run 8 codes, 0 = run one code; sampled with start.
- start_code  input  3  first code applied; sampled with start.
- x, y, z  output  1 each  drive to the function block; {x,y,z} = current code.
- A, B, C  input  1 each  outputs returned from the function block.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse in DONE.
- result_valid  output  1  one-cycle pulse per sampled code.
- result_code  output  3  code belonging to result_abc.
- result_abc  output  3  sampled {A,B,C}.
- mismatch_count  output  4  failed codes this run (0..8).
- pass  output  1  1 when mismatch_count == 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → latch code <= start_code, remaining <= (sweep ? 7 : 0), settle counter <= SETTLE-1, mismatch_count <= 0; go to SETTLE.
- SETTLE: counter == 0 → SAMPLE, else decrement.
- SAMPLE: on exit edge, register result_code <= code, result_abc <= {A,B,C}, result_valid <= 1; compare with golden and increment mismatch_count on difference. If remaining == 0 → DONE; else code <= code + 1 (3-bit wrap, 7 → 0), remaining--, reload counter, go to SETTLE.
- DONE: one cycle, then IDLE. result_code/result_abc/mismatch_count/pass hold until the next start.
- start while busy or in DONE: ignored, not queued.
- Golden {A,B,C} per code 0..7: 010, 011, 100, 101, 001, 010, 011, 100.
- reset (any state, including mid-sweep): state IDLE, x=y=z=0, busy=0, done=0, result_valid=0, result_code=0, result_abc=0, mismatch_count=0, pass=1. The run is abandoned with no done pulse.

## Timing
- All outputs registered or decoded from the state register; no combinational path from A/B/C or start to any output.
- {x,y,z} updates on the edge that enters SETTLE. It is stable for SETTLE+1 cycles before the sampling edge.
- Per-code period: SETTLE+1 cycles.
- Start accepted at edge 0: first result_valid is high in the cycle after edge SETTLE+1. Each later result follows every SETTLE+1 cycles.
- Single-code run: done is high in the cycle after edge SETTLE+1, concurrent with result_valid.
- 8-code run: done is high in the cycle after edge 8·(SETTLE+1), concurrent with the last result_valid. IDLE follows on the next edge.
- A new start is accepted on the edge after done.

## Configuration
- CIRCUIT_4_5_SWEEP_CHECK_EN defined: golden compare compiled in; mismatch_count and pass behave as above.
- Not defined: no golden logic. mismatch_count is constant 0 and pass is constant 1. Sequencing and result streaming are unchanged.

## Test plan
- Reset, then sweep=1, start_code=0, SETTLE=1, correct block attached → result_abc stream 010,011,100,101,001,010,011,100 for codes 0..7; done after edge 16; mismatch_count=0, pass=1.
- sweep=1, start_code=5 → result_code order 5,6,7,0,1,2,3,4 (wrap checked); 8 result_valid pulses, 1 done.
- sweep=0, start_code=3, SETTLE=4 → {x,y,z}=011 held 5 cycles; single result_abc=101; done in the cycle after edge 5.
- Block's C output forced to 0, full sweep → mismatch_count=4 (codes 1,3,4,6), pass=0 (CHECK_EN build); mismatch_count=0, pass=1 (non-CHECK_EN build).
- start pulsed at cycles 3 and 9 of a running sweep → ignored; exactly 8 results and 1 done.
- reset asserted after the 4th result_valid → next cycle IDLE, all outputs at reset values, no done. A fresh start then runs a clean 8-code sweep.

Source files
------------

// File: rtl/circuit_4_5_sweep.sv
// circuit_4_5_sweep: clocked, handshaked sweep of the 3-in/3-out function block
// (A = x'y + yz, B = xyz' + x'y' + y'z, C = x ^ z). Each code is applied, held
// for SETTLE cycles, and sampled. Every result is streamed out.
// Optional macro CIRCUIT_4_5_SWEEP_CHECK_EN compiles in the golden compare
// that drives mismatch_count and pass. When the macro is undefined,
// mismatch_count is 0 and pass is 1.
module circuit_4_5_sweep #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       sweep,
   input  logic [2:0] start_code,
   output logic       x,
   output logic       y,
   output logic       z,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   output logic       busy,
   output logic       done,
   output logic       result_valid,
   output logic [2:0] result_code,
   output logic [2:0] result_abc,
   output logic [3:0] mismatch_count,
   output logic       pass
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic [2:0]       r_code;
   logic [2:0]       r_remaining;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_valid;
   logic [2:0]       r_result_code;
   logic [2:0]       r_result_abc;
   logic [2:0]       w_abc;

   assign w_abc = {A, B, C};

`ifdef CIRCUIT_4_5_SWEEP_CHECK_EN
   logic [3:0] r_mismatch;

   // Expected {A,B,C} for each input code of a correct function block
   function automatic logic [2:0] golden_abc(input logic [2:0] code);
      case (code)
         3'd0:    golden_abc = 3'b010;
         3'd1:    golden_abc = 3'b011;
         3'd2:    golden_abc = 3'b100;
         3'd3:    golden_abc = 3'b101;
         3'd4:    golden_abc = 3'b001;
         3'd5:    golden_abc = 3'b010;
         3'd6:    golden_abc = 3'b011;
         default: golden_abc = 3'b100;
      endcase
   endfunction

   // Count failing codes within the current run; cleared on start and reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mismatch <= 4'd0;
      end else if (r_state == S_IDLE && start) begin
         r_mismatch <= 4'd0;
      end else if (r_state == S_SAMPLE && w_abc != golden_abc(r_code)) begin
         r_mismatch <= r_mismatch + 4'd1;
      end
   end

   assign mismatch_count = r_mismatch;
   assign pass           = (r_mismatch == 4'd0);
`else
   assign mismatch_count = 4'd0;
   assign pass           = 1'b1;
`endif

   // Sweep sequencer: state, applied code, settle timing and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_code        <= 3'd0;
         r_remaining   <= 3'd0;
         r_cnt         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_valid       <= 1'b0;
         r_result_code <= 3'd0;
         r_result_abc  <= 3'd0;
      end else begin
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_code      <= start_code;
                  r_remaining <= sweep ? 3'd7 : 3'd0;
                  r_cnt       <= SETTLE_RELOAD;
                  r_busy      <= 1'b1;
                  r_state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_SAMPLE: begin
               r_result_code <= r_code;
               r_result_abc  <= w_abc;
               r_valid       <= 1'b1;
               if (r_remaining == 3'd0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_code      <= r_code + 3'd1;
                  r_remaining <= r_remaining - 3'd1;
                  r_cnt       <= SETTLE_RELOAD;
                  r_state     <= S_SETTLE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign {x, y, z}    = r_code;
   assign busy         = r_busy;
   assign done         = r_done;
   assign result_valid = r_valid;
   assign result_code  = r_result_code;
   assign result_abc   = r_result_abc;

endmodule

// File: tb/tb_circuit_4_5_sweep.sv
// tb_circuit_4_5_sweep: directed and randomized runs of circuit_4_5_sweep
// with SETTLE=1 and SETTLE=4, each driving a behavioural function block.
module tb_circuit_4_5_sweep;

   logic       clk = 1'b0;
   logic       reset;
   logic       sweep;
   logic [2:0] start_code;
   logic       fault;
   logic       start1, start4;
   logic       sel4;

   logic       x1, y1, z1, a1, b1, c1, busy1, done1, rv1, pass1;
   logic [2:0] rc1, rabc1;
   logic [3:0] mm1;
   logic       x4, y4, z4, a4, b4, c4, busy4, done4, rv4, pass4;
   logic [2:0] rc4, rabc4;
   logic [3:0] mm4;

   logic [2:0] m_xyz, m_rc, m_rabc;
   logic       m_busy, m_done, m_rv, m_pass;
   logic [3:0] m_mm;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   circuit_4_5_sweep #(.SETTLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .sweep(sweep), .start_code(start_code),
      .x(x1), .y(y1), .z(z1), .A(a1), .B(b1), .C(c1),
      .busy(busy1), .done(done1), .result_valid(rv1), .result_code(rc1),
      .result_abc(rabc1), .mismatch_count(mm1), .pass(pass1));

   circuit_4_5_sweep #(.SETTLE(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .sweep(sweep), .start_code(start_code),
      .x(x4), .y(y4), .z(z4), .A(a4), .B(b4), .C(c4),
      .busy(busy4), .done(done4), .result_valid(rv4), .result_code(rc4),
      .result_abc(rabc4), .mismatch_count(mm4), .pass(pass4));

   // Function block from its boolean equations; f forces C low
   function automatic logic [2:0] block_abc(input logic [2:0] code, input logic f);
      logic xx, yy, zz, a, b, c;
      {xx, yy, zz} = code;
      a = (!xx && yy) || (yy && zz);
      b = (xx && yy && !zz) || (!xx && !yy) || (!yy && zz);
      c = f ? 1'b0 : (xx ^ zz);
      return {a, b, c};
   endfunction

   always_comb {a1, b1, c1} = block_abc({x1, y1, z1}, fault);
   always_comb {a4, b4, c4} = block_abc({x4, y4, z4}, fault);

   always_comb begin
      m_xyz  = sel4 ? {x4, y4, z4} : {x1, y1, z1};
      m_busy = sel4 ? busy4 : busy1;
      m_done = sel4 ? done4 : done1;
      m_rv   = sel4 ? rv4   : rv1;
      m_rc   = sel4 ? rc4   : rc1;
      m_rabc = sel4 ? rabc4 : rabc1;
      m_mm   = sel4 ? mm4   : mm1;
      m_pass = sel4 ? pass4 : pass1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel4) start4 = v;
      else start1 = v;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_xyz"},  16'(m_xyz),  16'd0);
      check({pfx, "_busy"}, 16'(m_busy), 16'd0);
      check({pfx, "_done"}, 16'(m_done), 16'd0);
      check({pfx, "_rv"},   16'(m_rv),   16'd0);
      check({pfx, "_rc"},   16'(m_rc),   16'd0);
      check({pfx, "_rabc"}, 16'(m_rabc), 16'd0);
      check({pfx, "_mm"},   16'(m_mm),   16'd0);
      check({pfx, "_pass"}, 16'(m_pass), 16'd1);
   endtask

   // One run on the selected DUT, checked cycle by cycle against the timing rules
   task automatic run(input logic [2:0] s, input logic sw, input logic f, input logic ign);
      int         per, n, total, nv, nd, mm_exp, mm_build, idx;
      logic [2:0] e_code [8];
      logic [2:0] e_abc  [8];
      logic       exp_rv;
      per    = sel4 ? 5 : 2;
      n      = sw ? 8 : 1;
      total  = n * per;
      mm_exp = 0;
      for (int i = 0; i < n; i++) begin
         e_code[i] = 3'(int'(s) + i);
         e_abc[i]  = block_abc(e_code[i], f);
         if (e_abc[i] != block_abc(e_code[i], 1'b0)) mm_exp++;
      end
`ifdef CIRCUIT_4_5_SWEEP_CHECK_EN
      mm_build = mm_exp;
`else
      mm_build = 0;
`endif
      @(negedge clk);
      sweep      = sw;
      start_code = s;
      fault      = f;
      drive_start(1'b1);
      nv = 0;
      nd = 0;
      for (int cyc = 0; cyc <= total + 1; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         drive_start(ign && (cyc + 1 == 3 || cyc + 1 == 9));
         if (cyc < total) begin
            check("busy", 16'(m_busy), 16'd1);
            check("xyz", 16'(m_xyz), 16'(e_code[cyc / per]));
         end else begin
            check("busy_end", 16'(m_busy), 16'd0);
         end
         exp_rv = (cyc > 0) && (cyc % per == 0) && (cyc <= total);
         check("result_valid", 16'(m_rv), 16'(exp_rv));
         if (exp_rv) begin
            idx = cyc / per - 1;
            check("result_code", 16'(m_rc), 16'(e_code[idx]));
            check("result_abc", 16'(m_rabc), 16'(e_abc[idx]));
         end
         check("done", 16'(m_done), 16'(cyc == total));
         if (m_rv) nv++;
         if (m_done) nd++;
      end
      check("n_results", 16'(nv), 16'(n));
      check("n_done", 16'(nd), 16'd1);
      check("mismatch_count", 16'(m_mm), 16'(mm_build));
      check("pass", 16'(m_pass), 16'(mm_build == 0));
      check("hold_code", 16'(m_rc), 16'(e_code[n-1]));
      check("hold_abc", 16'(m_rabc), 16'(e_abc[n-1]));
   endtask

   initial begin
      int cnt, saw_done;
      reset = 1'b1; start1 = 1'b0; start4 = 1'b0; sweep = 1'b0;
      start_code = 3'd0; fault = 1'b0; sel4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst1");
      sel4 = 1'b1;
      check_reset_vals("rst4");
      sel4 = 1'b0;
      reset = 1'b0;

      run(3'd0, 1'b1, 1'b0, 1'b0);
      run(3'd5, 1'b1, 1'b0, 1'b0);
      sel4 = 1'b1;
      run(3'd3, 1'b0, 1'b0, 1'b0);
      sel4 = 1'b0;
      run(3'd0, 1'b1, 1'b1, 1'b0);
      run(3'd2, 1'b1, 1'b0, 1'b1);

      // Abort a sweep with reset after its 4th result
      @(negedge clk);
      sweep = 1'b1; start_code = 3'd1; fault = 1'b0; start1 = 1'b1;
      cnt = 0; saw_done = 0;
      for (int k = 0; k < 40 && cnt < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         if (rv1) cnt++;
         if (done1) saw_done++;
      end
      check("abort_results", 16'(cnt), 16'd4);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("abort");
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done1) saw_done++;
      check("abort_no_done", 16'(saw_done), 16'd0);
      check("abort_idle_busy", 16'(busy1), 16'd0);
      run(3'd0, 1'b1, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         sel4 = 1'($urandom_range(0, 1));
         run(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
